// File: rtl/mix_line_printer.sv
// mix_line_printer: buffers one MIX printer line, strips trailing blanks, emits ASCII bytes then CR LF.
//   word_in/word_valid/word_ready : 30-bit MIX words in, char 0 in bits [29:24]
//   byte_out/byte_valid/byte_ready : ASCII bytes out to the UART transmitter
//   busy                           : line accepted and not yet fully printed
module mix_line_printer #(
   parameter int LINE_WORDS = 24,
   parameter int CHARS = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy
);
   localparam int NCH = LINE_WORDS * CHARS;
   localparam int CW = $clog2(LINE_WORDS);
   localparam int PW = $clog2(NCH);
   localparam logic [127:0] PUNCT = ".,()+-*/=$<>@;:'";
   typedef enum logic [2:0] {IDLE, FILL, EMIT, CR, LF} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] count;
   logic [PW-1:0] ptr, last, word_last;
   logic last_ok, w_xfer, b_xfer, word_nz, final_word, any_nz;
   logic [2:0] pos;
   logic [5:0] chars [NCH];
   function automatic logic [7:0] to_ascii(input logic [5:0] c);
      logic [7:0] v = {2'b00, c};
      return c == 6'd0  ? 8'h20 :
             c <= 6'd9  ? 8'h40 + v :
             c == 6'd10 ? 8'h5E :
             c <= 6'd19 ? 8'h3F + v :
             c == 6'd20 ? 8'h5B :
             c == 6'd21 ? 8'h23 :
             c <= 6'd29 ? 8'h3D + v :
             c <= 6'd39 ? 8'h12 + v :
             c <= 6'd55 ? PUNCT[8*(55-int'(c)) +: 8] : 8'h3F;
   endfunction
   assign w_xfer = word_valid & word_ready;
   assign b_xfer = byte_valid & byte_ready;
   assign byte_valid = state == EMIT || state == CR || state == LF;
   assign byte_out = state == EMIT ? to_ascii(chars[ptr]) :
                     state == CR   ? 8'h0D :
                     state == LF   ? 8'h0A : 8'h00;
   always_comb begin
      // rightmost nonzero char of the incoming word wins
      pos = 3'd0;
      for (int i = 0; i < CHARS; i++)
         if (word_in[(CHARS-1-i)*6 +: 6] != 6'd0) pos = i[2:0];
      word_nz = |word_in;
      word_last = PW'(count) * PW'(CHARS) + PW'(pos);
      final_word = count == CW'(LINE_WORDS - 1);
      // the flag is stale from the previous line until the first word lands
      any_nz = word_nz | (state == FILL & last_ok);
      state_nxt = state;
      case (state)
         IDLE, FILL: if (w_xfer) state_nxt = final_word ? (any_nz ? EMIT : CR) : FILL;
         EMIT:       if (b_xfer && ptr == last) state_nxt = CR;
         CR:         if (b_xfer) state_nxt = LF;
         LF:         if (b_xfer) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         ptr <= '0;
         last <= '0;
         last_ok <= 1'b0;
         word_ready <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_nxt;
         word_ready <= state_nxt == IDLE || state_nxt == FILL;
         busy <= state_nxt != IDLE;
         if (w_xfer) begin
            count <= final_word ? '0 : count + 1'b1;
            ptr <= '0;
            if (word_nz) begin
               last <= word_last;
               last_ok <= 1'b1;
            end else if (state == IDLE) last_ok <= 1'b0;
         end else if (state == EMIT && b_xfer) ptr <= ptr + 1'b1;
      end
   end
   // every word slot is rewritten each line, so the buffer needs no reset
   always_ff @(posedge clk)
      if (w_xfer)
         for (int i = 0; i < CHARS; i++)
            chars[int'(count)*CHARS+i] <= word_in[(CHARS-1-i)*6 +: 6];
endmodule

// File: tb/tb_mix_line_printer.sv
// tb_mix_line_printer: directed and randomized lines checked against a table-driven line model.
module tb_mix_line_printer;
   logic        clk = 1'b0, reset = 1'b1;
   logic [29:0] word_in = '0;
   logic        word_valid = 1'b0, word_ready;
   logic [7:0]  byte_out;
   logic        byte_valid, byte_ready = 1'b0, busy;
   int checks = 0, failures = 0;
   logic [29:0] line [24];
   byte exp_q[$], got_q[$];
   string tbl = " ABCDEFGHI^JKLMNOPQR[#STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

   mix_line_printer dut (
      .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
      .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic build_exp();
      int lst = -1;
      logic [5:0] c;
      exp_q.delete();
      for (int k = 0; k < 120; k++) begin
         c = line[k/5][29-6*(k%5) -: 6];
         if (c != 6'd0) lst = k;
      end
      for (int k = 0; k <= lst; k++) begin
         c = line[k/5][29-6*(k%5) -: 6];
         exp_q.push_back(tbl[c]);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic send(input int n, input bit gaps);
      int i = 0, budget = 0;
      bit t;
      while (i < n) begin
         word_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         word_in = word_valid ? line[i] : 30'($urandom);
         t = word_valid && word_ready;
         step();
         if (t) i++;
         if (++budget > 500) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      word_valid = 1'b0;
   endtask

   task automatic recv(input bit stall);
      int budget = 0;
      bit t, held_v = 0;
      logic [7:0] held, b;
      got_q.delete();
      check("first_byte_valid", byte_valid, 1);
      check("ready_low_in_emit", word_ready, 0);
      forever begin
         if (held_v) begin
            check("stall_valid", byte_valid, 1);
            check("stall_hold", byte_out, held);
         end
         byte_ready = stall ? $urandom_range(0, 1) : 1'b1;
         word_valid = $urandom_range(0, 1);
         word_in = 30'($urandom);
         t = byte_valid && byte_ready;
         held_v = byte_valid && !byte_ready;
         held = byte_out;
         b = byte_out;
         step();
         if (t) begin
            got_q.push_back(b);
            if (b == 8'h0A) break;
         end
         if (++budget > 1000) begin
            check("recv_timeout", 0, 1);
            break;
         end
      end
      byte_ready = 1'b0;
      word_valid = 1'b0;
      check("busy_after_lf", busy, 0);
      check("ready_after_lf", word_ready, 1);
   endtask

   task automatic compare(input string tag);
      build_exp();
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
         check({tag, "_byte"}, got_q[k], exp_q[k]);
   endtask

   task automatic run_line(input string tag, input bit gaps, input bit stall);
      send(24, gaps);
      recv(stall);
      compare(tag);
   endtask

   initial begin
      step();
      step();
      check("rst_word_ready", word_ready, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_byte_out", byte_out, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      step();
      check("idle_ready", word_ready, 1);
      check("idle_busy", busy, 0);

      foreach (line[w]) line[w] = '0;
      line[0] = 30'o0102030405;
      run_line("abcde", 0, 0);
      check("abcde_len_const", got_q.size(), 7);
      if (got_q.size() == 7) begin
         check("abcde_A", got_q[0], 8'h41);
         check("abcde_E", got_q[4], 8'h45);
         check("abcde_CR", got_q[5], 8'h0D);
      end

      foreach (line[w]) line[w] = '0;
      run_line("blank", 1, 0);
      check("blank_len_const", got_q.size(), 2);

      line[23] = 30'o36;
      run_line("last_char", 0, 0);
      check("last_len_const", got_q.size(), 122);
      if (got_q.size() == 122) begin
         check("last_space", got_q[118], 8'h20);
         check("last_zero", got_q[119], 8'h30);
      end

      for (int l = 0; l < 5; l++) begin
         for (int k = 0; k < 120; k++)
            line[k/5][29-6*(k%5) -: 6] = 6'((l*120 + k) % 64);
         run_line("sweep", l[0], l[1]);
         if (l == 0 && got_q.size() > 63) begin
            check("delta", got_q[10], 8'h5E);
            check("sigma", got_q[20], 8'h5B);
            check("pi", got_q[21], 8'h23);
            check("quote", got_q[55], 8'h27);
            check("query", got_q[63], 8'h3F);
         end
      end

      for (int r = 0; r < 6; r++) begin
         foreach (line[w])
            for (int p = 0; p < 5; p++)
               line[w][29-6*p -: 6] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         if (r[0]) for (int w = 12 + r; w < 24; w++) line[w] = '0;
         run_line("random_stall", 1, 1);
      end

      for (int k = 0; k < 24; k++) line[k] = 30'($urandom);
      send(10, 0);
      check("abort_busy_pre", busy, 1);
      reset = 1'b1;
      step();
      check("abort_rst_ready", word_ready, 0);
      check("abort_rst_busy", busy, 0);
      reset = 1'b0;
      step();
      check("abort_ready", word_ready, 1);
      check("abort_busy", busy, 0);
      foreach (line[w]) line[w] = '0;
      line[0] = 30'o0102030405;
      run_line("after_abort", 0, 0);
      check("after_abort_len_const", got_q.size(), 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mix_line_printer.md
Name: mix_line_printer

Overview:
- Downstream consumer of the MIX OUT unit's word stream: formats one printer line, 24 MIX words = 120 six-bit characters, into an ASCII byte stream for the UART transmitter.
- Buffers the full line, strips trailing blanks, translates MIX character codes to ASCII and appends CR LF.
- Sits between the OUT device logic (word producer) and the byte-level tx serializer (byte consumer).

Parameters:
- LINE_WORDS, 24, words per printed line (MIX line printer block size).
- CHARS, 5, characters per word (fixed by the MIX word format; not to be overridden).

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- word_in  input  30  MIX word magnitude; char 0 = bits [29:24], char 4 = bits [5:0].
- word_valid  input  1  word_in valid.
- word_ready  output  1  block can accept a word this cycle.
- byte_out  output  8  ASCII byte to the transmitter.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  transmitter takes byte_out this cycle.
- busy  output  1  line in progress; OUT unit uses it for JBUS/JRED.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: word_ready=0, byte_valid=0, byte_out=8'h00, busy=0. Also state=IDLE, word count=0, last-nonblank flag clear.
- Reset mid-line aborts the line and discards the buffer. The next line starts clean.
- Handshakes:
  - Word transfer occurs on a cycle with word_valid & word_ready.
  - Byte transfer occurs on a cycle with byte_valid & byte_ready.
  - byte_out must hold stable while byte_valid=1 and byte_ready=0.
- States:
  - IDLE: word_ready=1, busy=0. A word transfer stores it as word 0, sets count=1, sets busy=1, and goes to FILL.
  - FILL: word_ready=1, busy=1. Each transfer stores the word at index count and increments count. When the transfer of word LINE_WORDS-1 occurs, go to EMIT with char pointer=0. word_ready drops the cycle after that transfer.
  - EMIT: word_ready=0. Present the ASCII of the char at the pointer; advance the pointer on each transfer. After the transfer of char index `last`, go to CR. If no nonblank char exists in the line, enter CR directly from FILL.
  - CR: byte_out=8'h0D. On transfer, go to LF.
  - LF: byte_out=8'h0A. On transfer, go to IDLE, busy=0, and word_ready=1 on the next cycle.
- Trailing-blank tracking: `last` = highest char index (0..119) whose code is nonzero. Update it during FILL as each word arrives: last = word_index*5 + position of the rightmost nonzero char in that word.
- Blank character: MIX code 0 (space). Interior blanks are emitted; only trailing blanks are dropped.
- Latency:
  - The first byte_valid is asserted the cycle after the final word transfer.
  - Back-to-back bytes when byte_ready is held high: one byte per cycle.
- Translation (MIX code -> ASCII):
  - 0 -> space.
  - 1-9 -> A-I; 10 -> '^' (delta); 11-19 -> J-R; 20 -> '[' (sigma); 21 -> '#' (pi); 22-29 -> S-Z.
  - 30-39 -> '0'-'9'.
  - 40-55 -> . , ( ) + - * / = $ < > @ ; : '
  - 56-63 -> '?'.
- Buffer: 120 x 6-bit characters (or 24 x 30-bit words), write on word transfer, read at pointer. Registered read is allowed provided byte_valid is not asserted until the data is valid.
- Simultaneous events: word_valid during EMIT/CR/LF is ignored, because word_ready=0. Reset takes priority over any handshake in the same cycle.

Test Plan:
- Line with word 0 = 0o0102030405 ("ABCDE") and words 1-23 = 0 -> bytes 41 42 43 44 45 0D 0A; busy falls after the 0A transfer.
- All 24 words = 0 -> exactly two bytes, 0D 0A; no space bytes.
- Word 23 = 0o0000000036 (char 119 = '0') and all other words 0 -> 119 x 0x20, then 0x30, 0D, 0A (122 bytes).
- byte_ready toggled pseudo-randomly -> byte_out stable while stalled. The byte sequence matches the ready=1 run. No byte is duplicated or dropped.
- Translation sweep: five lines carrying codes 0-63 in order -> ASCII per the table. 10, 20 and 21 give 5E, 5B, 23; 56-63 give 3F.
- Reset asserted after 10 words of a line -> busy=0 and word_ready=1 the cycle after reset deasserts. The next line "ABCDE" prints correctly with no residue from the aborted line.
